l2_cache_ctrl: RTL and testbench

Control and datapath-steering block for the 2-way, 8-set, 256-bit-line L2 cache. It drives index, tag, data, byte-enable and load strobes into two way instances and reads back their tag/valid/dirty/data. It runs hit/miss detection, true-LRU victim selection, dirty writeback and line fill against physical memory. It sits between the L1/arbiter request port and the pmem port.

---
 rtl/l2_cache_ctrl.sv | 141 ++++++++++++++
 tb/tb_l2_cache_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_ctrl.sv
// Controller for the 2-way, 8-set, 256-bit-line L2: hit/miss, true-LRU victim,
// dirty writeback and line fill, steering the external way arrays.
module l2_cache_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata,
    input  logic [31:0]  mem_byte_enable,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [2:0]   way_index_o,
    output logic [23:0]  way_tag_o,
    output logic [255:0] way_data_o,
    output logic [1:0]   way_load_o,
    output logic [1:0]   way_load_dirty_o,
    output logic         way_mem_write_o,
    output logic [31:0]  way0_be_o,
    output logic [31:0]  way1_be_o,
    input  logic [23:0]  way0_tag_i,
    input  logic [23:0]  way1_tag_i,
    input  logic [1:0]   way_valid_i,
    input  logic [1:0]   way_dirty_i,
    input  logic [255:0] way0_data_i,
    input  logic [255:0] way1_data_i
);

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, SETTLE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  lru;
    logic [23:0] req_tag;
    logic [2:0]  req_idx;
    logic        req_write;
    logic        victim;
    logic        hit0, hit1, hit, hit_way, victim_sel, victim_dirty;
    logic        unused_addr;

    assign unused_addr = ^mem_address[4:0];

    // Way0 wins if both ways claim the tag.
    assign hit0    = way_valid_i[0] & (way0_tag_i == req_tag);
    assign hit1    = way_valid_i[1] & (way1_tag_i == req_tag) & ~hit0;
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    assign victim_sel   = !way_valid_i[0] ? 1'b0 : (!way_valid_i[1] ? 1'b1 : lru[req_idx]);
    assign victim_dirty = way_valid_i[victim_sel] & way_dirty_i[victim_sel];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lru       <= '0;
            req_tag   <= '0;
            req_idx   <= '0;
            req_write <= 1'b0;
            victim    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (mem_read || mem_write)) begin
                req_tag   <= mem_address[31:8];
                req_idx   <= mem_address[7:5];
                req_write <= mem_write;
            end
            if (state == COMPARE) begin
                if (hit) lru[req_idx] <= ~hit_way;
                else     victim       <= victim_sel;
            end
            if (state == FILL && pmem_resp) lru[req_idx] <= ~victim;
        end
    end

    always_comb begin
        state_nxt        = state;
        mem_rdata        = '0;
        mem_resp         = 1'b0;
        pmem_address     = '0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_wdata       = '0;
        way_tag_o        = req_tag;
        way_data_o       = '0;
        way_load_o       = '0;
        way_load_dirty_o = '0;
        way_mem_write_o  = 1'b0;
        way0_be_o        = '0;
        way1_be_o        = '0;
        // Index is gated by reset so every output reads 0 while rst is low.
        way_index_o      = !rst ? 3'd0 : (state == IDLE ? mem_address[7:5] : req_idx);

        case (state)
            IDLE: if (mem_read || mem_write) state_nxt = COMPARE;
            COMPARE: begin
                if (hit) begin
                    mem_resp  = 1'b1;
                    state_nxt = IDLE;
                    if (req_write) begin
                        way_data_o                = mem_wdata;
                        way_load_dirty_o[hit_way] = 1'b1;
                        way_mem_write_o           = 1'b1;
                        if (hit_way) way1_be_o = mem_byte_enable;
                        else         way0_be_o = mem_byte_enable;
                    end else begin
                        mem_rdata = hit_way ? way1_data_i : way0_data_i;
                    end
                end else begin
                    state_nxt = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {(victim ? way1_tag_i : way0_tag_i), req_idx, 5'b0};
                pmem_wdata   = victim ? way1_data_i : way0_data_i;
                if (pmem_resp) state_nxt = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, 5'b0};
                if (pmem_resp) begin
                    way_data_o               = pmem_rdata;
                    way_load_o[victim]       = 1'b1;
                    way_load_dirty_o[victim] = 1'b1;
                    if (victim) way1_be_o = '1;
                    else        way0_be_o = '1;
                    state_nxt = SETTLE;
                end
            end
            // Data read is registered; give it one edge to pick up the new line.
            SETTLE:  state_nxt = COMPARE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed bench for l2_cache_ctrl with a behavioural model of the two way arrays.
module tb_l2_cache_ctrl;

    logic         clk, rst;
    logic [31:0]  mem_address;
    logic         mem_read, mem_write;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_byte_enable;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic [2:0]   way_index_o;
    logic [23:0]  way_tag_o;
    logic [255:0] way_data_o;
    logic [1:0]   way_load_o, way_load_dirty_o;
    logic         way_mem_write_o;
    logic [31:0]  way0_be_o, way1_be_o;
    logic [23:0]  way0_tag_i, way1_tag_i;
    logic [1:0]   way_valid_i, way_dirty_i;
    logic [255:0] way0_data_i, way1_data_i;

    l2_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .way_index_o(way_index_o), .way_tag_o(way_tag_o), .way_data_o(way_data_o),
        .way_load_o(way_load_o), .way_load_dirty_o(way_load_dirty_o),
        .way_mem_write_o(way_mem_write_o), .way0_be_o(way0_be_o), .way1_be_o(way1_be_o),
        .way0_tag_i(way0_tag_i), .way1_tag_i(way1_tag_i),
        .way_valid_i(way_valid_i), .way_dirty_i(way_dirty_i),
        .way0_data_i(way0_data_i), .way1_data_i(way1_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Way arrays: tag/valid/dirty read combinationally, data read registered.
    logic [23:0]  tg [2][8];
    logic         vl [2][8];
    logic         dt [2][8];
    logic [255:0] dat[2][8];
    logic [255:0] rd0, rd1;
    logic         wipe;

    assign way0_tag_i  = tg[0][way_index_o];
    assign way1_tag_i  = tg[1][way_index_o];
    assign way_valid_i = {vl[1][way_index_o], vl[0][way_index_o]};
    assign way_dirty_i = {dt[1][way_index_o], dt[0][way_index_o]};
    assign way0_data_i = rd0;
    assign way1_data_i = rd1;

    always @(posedge clk) begin
        if (wipe) begin
            rd0 <= '0;
            rd1 <= '0;
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 8; s++) begin
                    tg[w][s]  <= '0;
                    vl[w][s]  <= 1'b0;
                    dt[w][s]  <= 1'b0;
                    dat[w][s] <= '0;
                end
        end else begin
            rd0 <= dat[0][way_index_o];
            rd1 <= dat[1][way_index_o];
            for (int w = 0; w < 2; w++) begin
                if (way_load_o[w]) begin
                    tg[w][way_index_o] <= way_tag_o;
                    vl[w][way_index_o] <= 1'b1;
                end
                if (way_load_dirty_o[w]) dt[w][way_index_o] <= way_mem_write_o;
                for (int b = 0; b < 32; b++)
                    if ((w == 0 ? way0_be_o[b] : way1_be_o[b]))
                        dat[w][way_index_o][b*8 +: 8] <= way_data_o[b*8 +: 8];
            end
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    logic [255:0] p1, p2, p3, w1, w2, p1w;

    initial begin
        p1  = {8{32'h1111_0001}};
        p2  = {8{32'h2222_0002}};
        p3  = {8{32'h3333_0003}};
        w1  = {8{32'h5555_55AA}};
        w2  = {8{32'h6666_7777}};
        p1w = {p1[255:32], w1[31:0]};

        rst = 1'b0; wipe = 1'b1;
        mem_address = 32'hFFFF_FFFF; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = '0; mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_index", way_index_o, 0);
        chk("rst_resp", {mem_resp, mem_rdata}, 0);
        chk("rst_pmem", {pmem_read, pmem_write, pmem_address}, 0);
        chk("rst_load", {way_load_o, way_load_dirty_o, way_mem_write_o, way0_be_o, way1_be_o}, 0);

        // Clean miss into way0 at index 1
        @(negedge clk); rst = 1'b1; wipe = 1'b0; mem_address = 32'h20; mem_read = 1'b1;
        #1 chk("idle_index", way_index_o, 1);
        chk("idle_resp", mem_resp, 0);
        @(negedge clk); #1 chk("cmp_miss", {mem_resp, pmem_read, pmem_write}, 0);
        @(negedge clk); #1 chk("fill_rd", {pmem_read, pmem_write}, 2'b10);
        chk("fill_addr", pmem_address, 32'h20);
        chk("fill_noload", way_load_o, 0);
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = p1;
        #1 chk("fill_load", way_load_o, 2'b01);
        chk("fill_be0", way0_be_o, 32'hFFFF_FFFF);
        chk("fill_be1", way1_be_o, 0);
        chk("fill_dirty", {way_load_dirty_o, way_mem_write_o}, 3'b010);
        chk("fill_data", way_data_o, p1);
        @(negedge clk); pmem_resp = 1'b0;
        #1 chk("settle", {mem_resp, pmem_read, pmem_write}, 0);
        @(negedge clk); #1 chk("miss_resp", mem_resp, 1);
        chk("miss_rdata", mem_rdata, p1);
        mem_read = 1'b0;

        // Read hit
        @(negedge clk); mem_read = 1'b1;
        #1 chk("hit_c0", mem_resp, 0);
        @(negedge clk); #1 chk("hit_resp", mem_resp, 1);
        chk("hit_rdata", mem_rdata, p1);
        chk("hit_nopmem", {pmem_read, pmem_write}, 0);
        mem_read = 1'b0;

        // Write hit, byte enables 0xF
        @(negedge clk); mem_write = 1'b1; mem_byte_enable = 32'h0000_000F; mem_wdata = w1;
        @(negedge clk); #1 chk("wr_resp", mem_resp, 1);
        chk("wr_be0", way0_be_o, 32'h0000_000F);
        chk("wr_be1", way1_be_o, 0);
        chk("wr_dirty", {way_load_dirty_o, way_mem_write_o}, 3'b011);
        chk("wr_data", way_data_o, w1);
        mem_write = 1'b0;
        @(negedge clk); mem_read = 1'b1;
        @(negedge clk); #1 chk("rd_after_wr", mem_rdata, p1w);
        chk("rd_byte0", mem_rdata[7:0], 8'hAA);
        mem_read = 1'b0;

        // Fill way1 with tag 1 at index 1; pmem_resp in the same cycle as the strobe
        @(negedge clk); mem_read = 1'b1; mem_address = 32'h120;
        @(negedge clk); #1 chk("cmp_miss2", {mem_resp, pmem_write}, 0);
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = p2;
        #1 chk("fill2_addr", pmem_address, 32'h120);
        chk("fill2_load", way_load_o, 2'b10);
        chk("fill2_be1", way1_be_o, 32'hFFFF_FFFF);
        @(negedge clk); pmem_resp = 1'b0;
        @(negedge clk); #1 chk("fill2_resp", mem_resp, 1);
        chk("fill2_rdata", mem_rdata, p2);
        mem_read = 1'b0;

        // Tag 2 at index 1: LRU victim way0 is dirty and must be written back
        @(negedge clk); mem_read = 1'b1; mem_address = 32'h220;
        @(negedge clk); #1 chk("cmp_miss3", {mem_resp, pmem_read, pmem_write}, 0);
        @(negedge clk); #1 chk("wb_strobe", {pmem_read, pmem_write}, 2'b01);
        chk("wb_addr", pmem_address, 32'h20);
        chk("wb_data", pmem_wdata, p1w);
        @(negedge clk); pmem_resp = 1'b1;
        #1 chk("wb_hold", {pmem_read, pmem_write}, 2'b01);
        @(negedge clk); pmem_resp = 1'b0;
        #1 chk("f3_strobe", {pmem_read, pmem_write}, 2'b10);
        chk("f3_addr", pmem_address, 32'h220);
        chk("f3_noload", way_load_o, 0);
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = p3;
        #1 chk("f3_load", way_load_o, 2'b01);
        @(negedge clk); pmem_resp = 1'b0;
        @(negedge clk); #1 chk("f3_resp", mem_resp, 1);
        chk("f3_rdata", mem_rdata, p3);
        chk("f3_clean", dt[0][1], 0);
        mem_read = 1'b0;

        // Reset while FILL is waiting on pmem
        @(negedge clk); mem_read = 1'b1; mem_address = 32'h340;
        @(negedge clk);
        @(negedge clk); #1 chk("rf_rd", pmem_read, 1);
        #1 rst = 1'b0; pmem_resp = 1'b1;
        #1 chk("rf_drop", {pmem_read, pmem_write}, 0);
        chk("rf_noload", {way_load_o, way_load_dirty_o}, 0);
        @(negedge clk); #1 chk("rf_valid", {vl[0][2], vl[1][2]}, 0);

        // Both strobes after reset: treated as a write hit on way1
        rst = 1'b1; pmem_resp = 1'b0; mem_read = 1'b1; mem_write = 1'b1;
        mem_address = 32'h120; mem_byte_enable = 32'hFFFF_0000; mem_wdata = w2;
        #1 chk("post_idle", way_index_o, 1);
        chk("post_resp", mem_resp, 0);
        @(negedge clk); #1 chk("both_resp", mem_resp, 1);
        chk("both_be1", way1_be_o, 32'hFFFF_0000);
        chk("both_be0", way0_be_o, 0);
        chk("both_dirty", {way_load_dirty_o, way_mem_write_o}, 3'b101);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
